// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider sequencer states and M-extension decode constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nx,
    output logic [XLEN-1:0] quo_nx
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // rem < dvs always holds, so the difference fits XLEN bits whenever it is non-negative
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign fits    = ~diff[XLEN];
    assign rem_nx  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx  = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/cpu_div_ctrl.sv
// RV32M divide sequencer: stalls EX during a 32-step restoring division, applies sign
// fix-up and the RISC-V divide-by-zero / overflow results, presents the result for one cycle.
module cpu_div_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            res,
    input  logic            divreq_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [XLEN-1:0] a_EX,
    input  logic [XLEN-1:0] b_EX,
    input  logic            kill_EX,
    output logic            stall_EX,
    output logic            divdone_EX,
    output logic [XLEN-1:0] divres_EX
);

    localparam int unsigned CNTW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            is_signed_q, is_rem_q, qneg_q, rneg_q;

    logic            accept;
    logic            op_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, ovf;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign accept    = (state == IDLE) && divreq_EX && funct3_EX[2] && !kill_EX;
    assign op_signed = ~funct3_EX[0];
    assign a_neg     = op_signed & a_EX[XLEN-1];
    assign b_neg     = op_signed & b_EX[XLEN-1];
    assign a_mag     = a_neg ? XLEN'(-a_EX) : a_EX;
    assign b_mag     = b_neg ? XLEN'(-b_EX) : b_EX;
    assign b_zero    = (b_EX == '0);
    assign ovf       = op_signed && (a_EX == MIN_NEG) && (b_EX == '1);

    assign quo_fix   = (is_signed_q && qneg_q) ? XLEN'(-quo_q) : quo_q;
    assign rem_fix   = (is_signed_q && rneg_q) ? XLEN'(-rem_q) : rem_q;

    // Stall is raised in the accept cycle itself so the operands stay put in EX
    assign stall_EX   = !kill_EX && (accept || state == CALC || state == FIX);
    assign divdone_EX = !kill_EX && (state == DONE);

    div_step #(.XLEN(XLEN)) u_step (
        .rem    (rem_q),
        .quo    (quo_q),
        .dvs    (dvs_q),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            divres_EX   <= '0;
        end else if (kill_EX) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_signed_q <= op_signed;
                        is_rem_q    <= funct3_EX[1];
                        qneg_q      <= a_neg ^ b_neg;
                        rneg_q      <= a_neg;
                        quo_q       <= a_mag;
                        dvs_q       <= b_mag;
                        rem_q       <= '0;
                        cnt         <= '0;
                        if (b_zero) begin
                            divres_EX <= funct3_EX[1] ? a_EX : '1;
                            state     <= DONE;
                        end else if (ovf) begin
                            divres_EX <= funct3_EX[1] ? '0 : MIN_NEG;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + CNTW'(1);
                    if (cnt == CNTW'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    divres_EX <= is_rem_q ? rem_fix : quo_fix;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
